plru_way_tracker: RTL and testbench
===================================

# plru_way_tracker

Per-set pseudo-LRU tracker and way encoder for the 4-way cache datapath. It takes the one-hot way vector produced by the tag-compare logic and encodes it to a 2-bit way index. On every recorded access it updates a 3-bit PLRU tree for the addressed set. It always presents the encoded victim way for the current set to the cache controller for miss fills.

## Interface
Parameters:
- NUM_SETS, 8, number of cache sets tracked
- INDEX_BITS, 3, set-index width; NUM_SETS == 2**INDEX_BITS

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- index  input  INDEX_BITS  set address for lookup and update
- access  input  1  record an access to set `index` this cycle
- hit_way  input  4  one-hot way-match vector, bit i = way i
- hit  output  1  OR of hit_way, combinational
- hit_idx  output  2  encoded hit_way, combinational; 0 when hit_way == 0 or multi-hot
- victim_idx  output  2  PLRU victim way of set `index`, combinational from the stored tree
- onehot_err  output  1  sticky flag: an access was seen with more than one hit_way bit set

## Operation
- Each set holds tree bits {b0,b1,b2}:
  - b0 = 0 selects the victim from ways {0,1}; b0 = 1 selects from {2,3}.
  - b1 selects between ways 0 and 1 (0 → way 0).
  - b2 selects between ways 2 and 3 (0 → way 2).
- victim_idx = b0 ? {1,b2} : {0,b1}.
- Update on the rising edge when access = 1, using the accessed way w:
  - w in {0,1}: b0 ← 1, b1 ← ~w[0], b2 unchanged.
  - w in {2,3}: b0 ← 0, b2 ← ~w[0], b1 unchanged.
- The accessed way w is chosen as follows:
  - hit_way one-hot: w = hit_idx.
  - hit_way == 0 (miss fill): w = current victim_idx of that set.
  - hit_way multi-hot: no tree update; onehot_err ← 1.
- access = 0: no state change, regardless of hit_way.
- Only set `index` is modified; all other sets hold their state.
- onehot_err stays set until rst.

## Timing
- hit, hit_idx, and victim_idx are combinational (zero latency).
- A tree update becomes visible on victim_idx the cycle after the access edge. In the access cycle itself, victim_idx shows the pre-update value.
- Back-to-back accesses to the same set on consecutive cycles each see the previous cycle's update. There is no forwarding hazard, because the next state is computed from the stored value at each edge.
- Reset behaviour:
  - rst = 1 at an edge clears every set to 000 and clears onehot_err. After reset, victim_idx = 0 for all sets.
  - rst takes priority over access in the same cycle; the access is dropped.
  - rst asserted mid-sequence discards all history with no partial updates.
- Outputs with rst held: victim_idx = 0 and onehot_err = 0. hit and hit_idx still follow hit_way.

## Structure
- Add to package lc3b_types:
  - lc3b_way (2-bit way index)
  - lc3b_plru (3-bit tree)
  - constant NUM_WAYS = 4
- Sub-module way_encoder: combinational 4→2 one-hot encoder. Outputs idx, any (the OR), and multi (multi-hot detect). Instantiate it once for hit_way.
- The state array is an lc3b_plru array of NUM_SETS entries, with the next-state function in a single always_comb block.

## Test plan
- Reset, then sweep index 0..7 with access = 0 → victim_idx = 0 for every set; onehot_err = 0.
- Set 3, one access each with hit_way = 0001, 0100, 0010, 1000 → victim_idx on the following cycles = 2, 1, 3, 0. Set 4 is unchanged (victim_idx = 0).
- Set 5 from reset, two accesses with hit_way = 0000 → the first fill uses way 0 (victim becomes 2); the second fill uses way 2 (victim becomes 1).
- Set 2, access with hit_way = 0110 → hit = 1, hit_idx = 0, tree unchanged (victim_idx = 0), onehot_err = 1 next cycle and held until rst.
- Set 1, accesses to ways 0 then 2 (victim_idx = 1), then rst together with access to way 1 → next cycle victim_idx = 0 for set 1 and onehot_err = 0.
- Combinational check, access = 0: hit_way = 1000 → hit = 1, hit_idx = 3; hit_way = 0000 → hit = 0, hit_idx = 0; no state change in either case.

Source files
------------

// File: rtl/plru_way_tracker_pkg.sv
// Shared types for the 4-way cache datapath: way index, PLRU tree encoding,
// and the victim-selection helper used by the tracker.
package lc3b_types;

    localparam int NUM_WAYS = 4;

    // Encoded way index (0..3)
    typedef logic [1:0] lc3b_way;

    // PLRU tree bits: [0] = b0 (half select), [1] = b1 (ways 0/1), [2] = b2 (ways 2/3)
    typedef logic [2:0] lc3b_plru;

    // Victim way pointed at by a tree: b0 picks the half, b1/b2 pick within it
    function automatic lc3b_way plru_victim(input lc3b_plru t);
        return t[0] ? {1'b1, t[2]} : {1'b0, t[1]};
    endfunction

endpackage

// File: rtl/plru_way_tracker_if.sv
// Lookup/update bus between the tag-compare logic, the cache controller and
// the PLRU tracker. The master drives the request, the slave (tracker)
// returns the encoded hit and victim information.
interface plru_way_tracker_if
    import lc3b_types::*;
#(
    parameter int INDEX_BITS = 3
);

    logic [INDEX_BITS-1:0] index;
    logic                  access;
    logic [NUM_WAYS-1:0]   hit_way;
    logic                  hit;
    lc3b_way               hit_idx;
    lc3b_way               victim_idx;
    logic                  onehot_err;

    modport master (
        output index, access, hit_way,
        input  hit, hit_idx, victim_idx, onehot_err
    );

    modport slave (
        input  index, access, hit_way,
        output hit, hit_idx, victim_idx, onehot_err
    );

endinterface

// File: rtl/plru_way_tracker_way_encoder.sv
// Combinational one-hot to binary way encoder. Multi-hot or all-zero
// inputs encode to way 0; callers use any/multi to tell these cases apart.
module way_encoder
    import lc3b_types::*;
(
    input  logic [NUM_WAYS-1:0] onehot,
    output lc3b_way             idx,
    output logic                any,
    output logic                multi
);

    // Encode the match vector and flag empty / multi-hot inputs
    always_comb begin
        idx   = '0;
        any   = |onehot;
        multi = any && ((onehot & (onehot - 4'd1)) != 4'd0);
        case (onehot)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/plru_way_tracker.sv
// Per-set tree pseudo-LRU tracker for a 4-way cache. Encodes the tag-compare
// match vector, updates the addressed set's tree on each recorded access, and
// presents the current victim way of the addressed set for miss fills.
module plru_way_tracker
    import lc3b_types::*;
#(
    parameter int NUM_SETS   = 8,
    parameter int INDEX_BITS = 3
) (
    input logic                  clk,
    input logic                  rst,
    plru_way_tracker_if.slave    bus
);

    lc3b_plru tree [NUM_SETS];
    logic     err_q;

    lc3b_way  enc_idx;
    logic     enc_any;
    logic     enc_multi;

    lc3b_plru cur_tree;
    lc3b_way  cur_victim;
    lc3b_way  acc_way;
    lc3b_plru tree_upd;
    logic     tree_we;

    way_encoder u_hit_enc (
        .onehot (bus.hit_way),
        .idx    (enc_idx),
        .any    (enc_any),
        .multi  (enc_multi)
    );

    // Next-state for the addressed set: a miss fill touches the current
    // victim, a multi-hot match is ignored so the tree is never corrupted
    always_comb begin
        cur_tree   = tree[bus.index];
        cur_victim = plru_victim(cur_tree);
        acc_way    = enc_any ? enc_idx : cur_victim;
        tree_upd   = cur_tree;
        tree_we    = bus.access && !enc_multi;
        if (!acc_way[1]) begin
            tree_upd[0] = 1'b1;
            tree_upd[1] = ~acc_way[0];
        end else begin
            tree_upd[0] = 1'b0;
            tree_upd[2] = ~acc_way[0];
        end
    end

    // Tree storage: reset wipes all history, otherwise only the addressed set moves
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                tree[i] <= '0;
            end
        end else if (tree_we) begin
            tree[bus.index] <= tree_upd;
        end
    end

    // Sticky multi-hot error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.access && enc_multi) begin
            err_q <= 1'b1;
        end
    end

    // Outputs: hit info follows hit_way directly; state-derived outputs read as cleared while reset is held
    always_comb begin
        bus.hit        = enc_any;
        bus.hit_idx    = enc_multi ? 2'd0 : enc_idx;
        bus.victim_idx = rst ? 2'd0 : cur_victim;
        bus.onehot_err = err_q && !rst;
    end

endmodule

// File: tb/tb_plru_way_tracker.sv
// Self-checking bench for plru_way_tracker: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the per-set PLRU trees.
module tb_plru_way_tracker;

    localparam int NSETS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total = 0;
    int bad   = 0;

    plru_way_tracker_if #(.INDEX_BITS(3)) bus ();

    plru_way_tracker #(.NUM_SETS(NSETS), .INDEX_BITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: three tree bits per set kept as separate arrays
    bit m_b0 [NSETS];
    bit m_b1 [NSETS];
    bit m_b2 [NSETS];
    bit m_err;

    function automatic int model_victim(input int s);
        if (m_b0[s]) return 2 + int'(m_b2[s]);
        return int'(m_b1[s]);
    endfunction

    function automatic int way_of(input logic [3:0] hw);
        for (int i = 0; i < 4; i++) if (hw[i]) return i;
        return 0;
    endfunction

    task automatic model_touch(input int s, input int w);
        if (w < 2) begin
            m_b0[s] = 1'b1;
            m_b1[s] = (w == 0);
        end else begin
            m_b0[s] = 1'b0;
            m_b2[s] = (w == 2);
        end
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare DUT against model each negedge, then advance model at posedge
    initial begin
        int s, ones, exp_hidx, exp_vic, exp_err;
        for (int i = 0; i < NSETS; i++) begin
            m_b0[i] = 0; m_b1[i] = 0; m_b2[i] = 0;
        end
        m_err = 0;
        forever begin
            @(negedge clk);
            s        = int'(bus.index);
            ones     = $countones(bus.hit_way);
            exp_hidx = (ones == 1) ? way_of(bus.hit_way) : 0;
            exp_vic  = rst ? 0 : model_victim(s);
            exp_err  = rst ? 0 : int'(m_err);
            check_val("model_hit", int'(bus.hit), (ones != 0) ? 1 : 0);
            check_val("model_hit_idx", int'(bus.hit_idx), exp_hidx);
            check_val("model_victim", int'(bus.victim_idx), exp_vic);
            check_val("model_err", int'(bus.onehot_err), exp_err);
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < NSETS; i++) begin
                    m_b0[i] = 0; m_b1[i] = 0; m_b2[i] = 0;
                end
                m_err = 0;
            end else if (bus.access) begin
                s    = int'(bus.index);
                ones = $countones(bus.hit_way);
                if (ones > 1) m_err = 1;
                else if (ones == 1) model_touch(s, way_of(bus.hit_way));
                else model_touch(s, model_victim(s));
            end
        end
    end

    task automatic applyStimulus(input int idx, input bit acc, input logic [3:0] hw, input bit r);
        @(posedge clk);
        #1;
        bus.index   = idx[2:0];
        bus.access  = acc;
        bus.hit_way = hw;
        rst         = r;
    endtask

    task automatic checkOutput(input string name, input int vic, input int err);
        @(negedge clk);
        check_val({name, "_victim"}, int'(bus.victim_idx), vic);
        check_val({name, "_err"}, int'(bus.onehot_err), err);
    endtask

    initial begin
        bus.index   = '0;
        bus.access  = 1'b0;
        bus.hit_way = '0;

        applyStimulus(0, 0, 4'b0000, 1);
        applyStimulus(0, 0, 4'b0000, 0);
        for (int i = 0; i < NSETS; i++) begin
            applyStimulus(i, 0, 4'b0000, 0);
            checkOutput("reset_sweep", 0, 0);
        end

        applyStimulus(3, 1, 4'b0001, 0);
        applyStimulus(3, 0, 4'b0000, 0); checkOutput("set3_w0", 2, 0);
        applyStimulus(3, 1, 4'b0100, 0);
        applyStimulus(3, 0, 4'b0000, 0); checkOutput("set3_w2", 1, 0);
        applyStimulus(3, 1, 4'b0010, 0);
        applyStimulus(3, 0, 4'b0000, 0); checkOutput("set3_w1", 3, 0);
        applyStimulus(3, 1, 4'b1000, 0);
        applyStimulus(3, 0, 4'b0000, 0); checkOutput("set3_w3", 0, 0);
        applyStimulus(4, 0, 4'b0000, 0); checkOutput("set4_untouched", 0, 0);

        applyStimulus(5, 1, 4'b0000, 0);
        applyStimulus(5, 0, 4'b0000, 0); checkOutput("set5_fill1", 2, 0);
        applyStimulus(5, 1, 4'b0000, 0);
        applyStimulus(5, 0, 4'b0000, 0); checkOutput("set5_fill2", 1, 0);

        applyStimulus(2, 1, 4'b0110, 0);
        @(negedge clk);
        check_val("multi_hit", int'(bus.hit), 1);
        check_val("multi_hit_idx", int'(bus.hit_idx), 0);
        applyStimulus(2, 0, 4'b0000, 0); checkOutput("multi_after", 0, 1);
        applyStimulus(6, 0, 4'b0000, 0); checkOutput("multi_held", 0, 1);

        applyStimulus(0, 0, 4'b1000, 0);
        @(negedge clk);
        check_val("comb_hit_w3", int'(bus.hit), 1);
        check_val("comb_idx_w3", int'(bus.hit_idx), 3);
        applyStimulus(0, 0, 4'b0000, 0);
        @(negedge clk);
        check_val("comb_hit_none", int'(bus.hit), 0);
        check_val("comb_idx_none", int'(bus.hit_idx), 0);
        checkOutput("comb_nochange", 0, 1);

        applyStimulus(1, 1, 4'b0001, 0);
        applyStimulus(1, 1, 4'b0100, 0);
        applyStimulus(1, 0, 4'b0000, 0); checkOutput("set1_pre_rst", 1, 1);
        applyStimulus(1, 1, 4'b0010, 1); checkOutput("set1_during_rst", 0, 0);
        applyStimulus(1, 0, 4'b0000, 0); checkOutput("set1_after_rst", 0, 0);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [3:0] hw;
            sel = int'($urandom_range(0, 9));
            if (sel < 2) hw = 4'b0000;
            else if (sel < 8) hw = 4'b0001 << $urandom_range(0, 3);
            else hw = 4'($urandom_range(0, 15));
            applyStimulus(int'($urandom_range(0, NSETS - 1)), ($urandom_range(0, 3) != 0),
                          hw, ($urandom_range(0, 99) == 0));
        end

        applyStimulus(0, 0, 4'b0000, 0);
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
